// File: rtl/dnn_pkg.sv
// -----------------------------------------------------------------------------
// dnn_pkg
// Types and constants shared between the DNN core and its row feeder.
//   - ST_IDLE / ST_FILL : row-assembler FSM encodings
//   - state_e           : enum view of the same encodings (debug visibility)
//   - row_vec_t         : row vector at the core's default geometry
//                         (element k sits in slot [k])
// -----------------------------------------------------------------------------
package dnn_pkg;

  localparam int DNN_DATA_WIDTH = 8;
  localparam int DNN_COL_NUM    = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  typedef logic [DNN_COL_NUM-1:0][DNN_DATA_WIDTH-1:0] row_vec_t;

endpackage

// File: rtl/dnn_row_assembler.sv
// -----------------------------------------------------------------------------
// dnn_row_assembler
// Packs a serial element stream into COL_NUM-wide rows for the DNN core and
// tracks the row position inside a ROW_NUM-row frame.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   en              : stream enable; low freezes intake and counters
//   stream_iv/or    : element valid / ready
//   stream_sof_i    : first element of a frame (qualified by stream_iv)
//   stream_id       : element data
//   row_ov          : one-cycle pulse, row_od holds a fresh row
//   row_od          : row vector, element k = k-th accepted element
//   row_idx_od      : row index inside the frame for row_od
//   frame_done_ov   : pulses with row_ov of the last row of a frame
//   frame_err_o     : sticky framing error (missing or premature sof)
//   state_dbg_o     : current FSM state
//
// Handshake: an element transfers on every rising edge where stream_iv and
// stream_or are both high; stream_or is simply en gated by reset, so the
// producer may see it drop combinationally. The output side has no ready:
// the DNN core always consumes.
// -----------------------------------------------------------------------------
module dnn_row_assembler
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  localparam int CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1,
  localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               stream_iv,
  input  logic                               stream_sof_i,
  input  logic [DATA_WIDTH-1:0]              stream_id,
  output logic                               stream_or,
  output logic                               row_ov,
  output logic [COL_NUM-1:0][DATA_WIDTH-1:0] row_od,
  output logic [RW-1:0]                      row_idx_od,
  output logic                               frame_done_ov,
  output logic                               frame_err_o,
  output state_e                             state_dbg_o
);

  logic [0:0]                         state_q, state_d;
  logic [CW-1:0]                      col_q, col_d;
  logic [RW-1:0]                      row_q, row_d;
  logic [COL_NUM-1:0][DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [COL_NUM-1:0][DATA_WIDTH-1:0] row_out_q, row_out_d;
  logic [RW-1:0]                      idx_q, idx_d;
  logic                               row_v_q, row_v_d;
  logic                               done_q, done_d;
  logic                               err_q, err_d;

  logic          accept;
  logic          take;
  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;

  assign stream_or = en & ~rst;
  assign accept    = stream_iv & stream_or;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    shadow_d  = shadow_q;
    row_out_d = row_out_q;
    idx_d     = idx_q;
    row_v_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    take      = 1'b0;
    eff_col   = '0;
    eff_row   = '0;

    // Decide where the accepted element lands. A sof always restarts the
    // frame at column 0 / row 0; it is only an error when it cuts into
    // something already in progress. A non-sof beat in IDLE is dropped.
    if (accept) begin
      if (stream_sof_i) begin
        take = 1'b1;
        if (state_q == ST_FILL && (col_q != '0 || row_q != '0)) begin
          err_d = 1'b1;
        end
      end else if (state_q == ST_FILL) begin
        take    = 1'b1;
        eff_col = col_q;
        eff_row = row_q;
      end else begin
        err_d = 1'b1;
      end
    end

    if (take) begin
      if (eff_col == CW'(COL_NUM - 1)) begin
        // Last column: the new element goes straight into the output row,
        // bypassing the shadow buffer, so the row is out one cycle later.
        for (int k = 0; k < COL_NUM; k++) begin
          row_out_d[k] = (k == COL_NUM - 1) ? stream_id : shadow_q[k];
        end
        idx_d   = eff_row;
        row_v_d = 1'b1;
        col_d   = '0;
        if (eff_row == RW'(ROW_NUM - 1)) begin
          done_d  = 1'b1;
          row_d   = '0;
          state_d = ST_IDLE;
        end else begin
          row_d   = eff_row + RW'(1);
          state_d = ST_FILL;
        end
      end else begin
        shadow_d[eff_col] = stream_id;
        col_d             = eff_col + CW'(1);
        row_d             = eff_row;
        state_d           = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      shadow_q  <= '0;
      row_out_q <= '0;
      idx_q     <= '0;
      row_v_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      shadow_q  <= shadow_d;
      row_out_q <= row_out_d;
      idx_q     <= idx_d;
      row_v_q   <= row_v_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign row_ov        = row_v_q;
  assign row_od        = row_out_q;
  assign row_idx_od    = idx_q;
  assign frame_done_ov = done_q;
  assign frame_err_o   = err_q;
  assign state_dbg_o   = state_e'(state_q);

endmodule
